// File: rtl/tpu_io_pkg.sv
// Shared types and default sizes for the TPU board-test I/O blocks.
// Used by the UB readback streamer and its byte serializer.
package tpu_io_pkg;

  localparam int         TPU_UB_ADDR_W = 8;
  localparam int         TPU_UB_DATA_W = 256;
  localparam logic [7:0] TPU_HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    RD,
    WAIT,
    SHIFT,
    CSUM
  } stream_state_t;

  function automatic int bytes_per_row(input int data_w);
    return data_w / 8;
  endfunction

  // A single-byte row still needs a one-bit index register.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_byte_serializer.sv
// Holds one UB row and hands it out a byte at a time, little-endian,
// keeping a running XOR of every byte handed out since the last clear.
module row_byte_serializer
  import tpu_io_pkg::*;
#(
  parameter int DATA_W = TPU_UB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_advance,
  output logic [7:0]        o_byte,
  output logic              o_last,
  output logic [7:0]        o_csum
);

  localparam int NBYTES = bytes_per_row(DATA_W);
  localparam int IDX_W  = index_width(NBYTES);

  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
    end else begin
      if (i_load) begin
        r_shift <= i_data;
        r_idx   <= '0;
      end else if (i_advance) begin
        r_shift <= r_shift >> 8;
        r_idx   <= r_idx + IDX_W'(1);
      end
      // The checksum folds in the byte on the cycle it leaves.
      if (i_clear) begin
        r_csum <= '0;
      end else if (i_advance) begin
        r_csum <= r_csum ^ r_shift[7:0];
      end
    end
  end

  assign o_byte = r_shift[7:0];
  assign o_last = (r_idx == IDX_W'(NBYTES - 1));
  assign o_csum = r_csum;

endmodule

// File: rtl/ub_readback_streamer.sv
// Reads a range of Unified Buffer rows and streams them as a framed byte
// sequence (header, row count, payload, XOR checksum) toward the UART TX path.
module ub_readback_streamer
  import tpu_io_pkg::*;
#(
  parameter int         UB_ADDR_W  = TPU_UB_ADDR_W,
  parameter int         UB_DATA_W  = TPU_UB_DATA_W,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] HDR_BYTE   = TPU_HDR_BYTE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [UB_ADDR_W-1:0] base_addr,
  input  logic [7:0]           num_rows,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ub_rd_en,
  output logic [UB_ADDR_W-1:0] ub_rd_addr,
  input  logic [UB_DATA_W-1:0] ub_rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  stream_state_t        r_state;
  stream_state_t        w_next;
  logic [UB_ADDR_W-1:0] r_addr;
  logic [8:0]           r_rows_left;
  logic [1:0]           r_lat;
  logic                 r_done;

  logic       w_xfer;
  logic       w_start_ok;
  logic       w_lat_last;
  logic       w_load;
  logic       w_shift;
  logic       w_row_done;
  logic [7:0] w_ser_byte;
  logic       w_ser_last;
  logic [7:0] w_csum;

  assign w_xfer     = tx_valid && tx_ready;
  assign w_start_ok = (r_state == IDLE) && start && !abort;
  assign w_lat_last = (r_lat == 2'(RD_LATENCY - 1));
  assign w_load     = (r_state == WAIT) && w_lat_last && !abort;
  assign w_shift    = (r_state == SHIFT) && w_xfer && !abort;
  assign w_row_done = w_shift && w_ser_last;

  row_byte_serializer #(
    .DATA_W(UB_DATA_W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_start_ok),
    .i_load   (w_load),
    .i_data   (ub_rd_data),
    .i_advance(w_shift),
    .o_byte   (w_ser_byte),
    .o_last   (w_ser_last),
    .o_csum   (w_csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort from any active state wins over everything, including a start in IDLE.
  always_comb begin
    w_next = r_state;
    if (abort && (r_state != IDLE)) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start_ok) w_next = HDR;
        HDR:     if (w_xfer) w_next = CNT;
        CNT:     if (w_xfer) w_next = RD;
        RD:      w_next = WAIT;
        WAIT:    if (w_lat_last) w_next = SHIFT;
        SHIFT:   if (w_xfer && w_ser_last) w_next = (r_rows_left == 9'd1) ? CSUM : RD;
        CSUM:    if (w_xfer) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Before any row is consumed, the low byte of rows_left is the raw count byte.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    ub_rd_en = 1'b0;
    case (r_state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      CNT: begin
        tx_valid = 1'b1;
        tx_data  = r_rows_left[7:0];
      end
      RD: begin
        ub_rd_en = 1'b1;
      end
      SHIFT: begin
        tx_valid = 1'b1;
        tx_data  = w_ser_byte;
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = w_csum;
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_rows_left <= '0;
      r_lat       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == CSUM) && w_xfer && !abort;
      if (w_start_ok) begin
        r_addr      <= base_addr;
        r_rows_left <= (num_rows == 8'd0) ? 9'd256 : {1'b0, num_rows};
      end else if (w_row_done) begin
        r_addr      <= r_addr + UB_ADDR_W'(1);
        r_rows_left <= r_rows_left - 9'd1;
      end
      if (r_state == RD) begin
        r_lat <= 2'd0;
      end else if ((r_state == WAIT) && !w_lat_last) begin
        r_lat <= r_lat + 2'd1;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign ub_rd_addr = r_addr;

endmodule

// File: tb/tb_ub_readback_streamer.sv
// Directed bench for ub_readback_streamer: a UB model with one-cycle read
// latency feeds the DUT while a negedge monitor records the byte stream.
module tb_ub_readback_streamer;

  localparam int AW = 8;
  localparam int DW = 256;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    num_rows = '0;
  logic          busy;
  logic          done;
  logic          ub_rd_en;
  logic [AW-1:0] ub_rd_addr;
  logic [DW-1:0] ub_rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;

  logic [DW-1:0] mem [256];

  int errors = 0;
  int checks = 0;

  logic [7:0]    rxQ [$];
  logic [7:0]    expQ[$];
  logic [7:0]    refQ[$];
  logic [AW-1:0] rdQ [$];
  int doneCount = 0;
  int busyCycles = 0;
  int stableViol = 0;
  int overlapViol = 0;
  logic       prevStall = 1'b0;
  logic       prevAbort = 1'b0;
  logic [7:0] prevData = 8'h00;

  ub_readback_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ub_rd_en  (ub_rd_en),
    .ub_rd_addr(ub_rd_addr),
    .ub_rd_data(ub_rd_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  // UB read port model: data only valid one cycle after a strobe, junk otherwise.
  always @(posedge clk) begin
    if (ub_rd_en) ub_rd_data <= mem[ub_rd_addr];
    else          ub_rd_data <= {8{$urandom()}};
  end

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rxQ.push_back(tx_data);
    if (ub_rd_en) rdQ.push_back(ub_rd_addr);
    if (done) doneCount++;
    if (busy) busyCycles++;
    if (busy && done) overlapViol++;
    if (prevStall && rst_n && !prevAbort && (!tx_valid || tx_data !== prevData)) stableViol++;
    prevStall = tx_valid && !tx_ready;
    prevAbort = abort;
    prevData  = tx_data;
  end

  function automatic logic [7:0] rowByte(input int r, input int k);
    if (r == 16) return 8'(k);
    return 8'(r * 7 + k * 29 + 8'h5C);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetMon();
    rxQ.delete();
    rdQ.delete();
    doneCount  = 0;
    busyCycles = 0;
  endtask

  task automatic buildExpected(input logic [7:0] b, input logic [7:0] n);
    int rows;
    logic [7:0] x;
    rows = (n == 8'd0) ? 256 : int'(n);
    x = 8'h00;
    expQ.delete();
    expQ.push_back(8'hA5);
    expQ.push_back(n);
    for (int i = 0; i < rows; i++) begin
      for (int k = 0; k < NB; k++) begin
        expQ.push_back(rowByte((int'(b) + i) % 256, k));
        x = x ^ rowByte((int'(b) + i) % 256, k);
      end
    end
    expQ.push_back(x);
  endtask

  task automatic checkFrame(input string tag);
    int mm;
    mm = 0;
    checkOutput({tag, " length"}, 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++)
      if (rxQ[i] !== expQ[i]) mm++;
    checkOutput({tag, " byte mismatches"}, 32'(mm), 32'd0);
  endtask

  // Caller sits just after a rising edge; start is held for exactly one cycle.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [7:0] n);
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
    end
    checkOutput({tag, " completes"}, 32'(ok), 32'd1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit reached;
    for (int r = 0; r < 256; r++)
      for (int k = 0; k < NB; k++)
        mem[r][k*8 +: 8] = rowByte(r, k);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset ub_rd_en", 32'(ub_rd_en), 32'd0);
    checkOutput("reset ub_rd_addr", 32'(ub_rd_addr), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single row at 0x10: A5 01 00..1F 00
    resetMon();
    applyStimulus(8'h10, 8'd1);
    checkOutput("hdr valid next cycle", 32'(tx_valid), 32'd1);
    checkOutput("hdr byte next cycle", 32'(tx_data), 32'hA5);
    waitIdle("row10", 200, 1'b0);
    buildExpected(8'h10, 8'd1);
    checkFrame("row10");
    checkOutput("row10 cnt byte", 32'(rxQ[1]), 32'h01);
    checkOutput("row10 first payload", 32'(rxQ[2]), 32'h00);
    checkOutput("row10 last payload", 32'(rxQ[33]), 32'h1F);
    checkOutput("row10 checksum", 32'(rxQ[34]), 32'h00);
    checkOutput("row10 done pulses", 32'(doneCount), 32'd1);
    checkOutput("row10 busy cycles", 32'(busyCycles), 32'd37);
    checkOutput("row10 reads", 32'(rdQ.size()), 32'd1);
    checkOutput("row10 read addr", 32'(rdQ[0]), 32'h10);

    // Address wrap FE, FF, 00
    resetMon();
    applyStimulus(8'hFE, 8'd3);
    waitIdle("wrap", 400, 1'b0);
    buildExpected(8'hFE, 8'd3);
    checkFrame("wrap");
    checkOutput("wrap bytes", 32'(rxQ.size()), 32'd99);
    checkOutput("wrap checksum", 32'(rxQ[98]), 32'(expQ[98]));
    checkOutput("wrap addr0", 32'(rdQ[0]), 32'hFE);
    checkOutput("wrap addr1", 32'(rdQ[1]), 32'hFF);
    checkOutput("wrap addr2", 32'(rdQ[2]), 32'h00);
    checkOutput("wrap done pulses", 32'(doneCount), 32'd1);
    refQ = rxQ;

    // Same frame under random backpressure
    resetMon();
    stableViol = 0;
    tx_ready = 1'b0;
    applyStimulus(8'hFE, 8'd3);
    waitIdle("backpressure", 2000, 1'b1);
    begin
      int mm;
      mm = 0;
      for (int i = 0; i < rxQ.size() && i < refQ.size(); i++)
        if (rxQ[i] !== refQ[i]) mm++;
      checkOutput("backpressure length", 32'(rxQ.size()), 32'(refQ.size()));
      checkOutput("backpressure vs ready run", 32'(mm), 32'd0);
    end
    checkOutput("backpressure stable data", 32'(stableViol), 32'd0);
    checkOutput("backpressure done pulses", 32'(doneCount), 32'd1);

    // num_rows 0 means 256 rows, wrapping back to base-1
    resetMon();
    applyStimulus(8'h40, 8'd0);
    waitIdle("rows256", 10000, 1'b0);
    buildExpected(8'h40, 8'd0);
    checkFrame("rows256");
    checkOutput("rows256 cnt byte", 32'(rxQ[1]), 32'h00);
    checkOutput("rows256 bytes", 32'(rxQ.size()), 32'd8195);
    checkOutput("rows256 reads", 32'(rdQ.size()), 32'd256);
    checkOutput("rows256 first addr", 32'(rdQ[0]), 32'h40);
    checkOutput("rows256 last addr", 32'(rdQ[255]), 32'h3F);
    checkOutput("rows256 done pulses", 32'(doneCount), 32'd1);

    // Abort during SHIFT of the second row
    resetMon();
    applyStimulus(8'h30, 8'd3);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rdQ.size() == 2) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("abort reached row2", 32'(reached), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("abort pre valid", 32'(tx_valid), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("abort no done", 32'(doneCount), 32'd0);
    checkOutput("abort no more reads", 32'(rdQ.size()), 32'd2);
    checkOutput("abort payload bytes", 32'(rxQ.size()), 32'd2 + 32'd32 + 32'd3);

    resetMon();
    applyStimulus(8'h20, 8'd1);
    waitIdle("post-abort", 200, 1'b0);
    buildExpected(8'h20, 8'd1);
    checkFrame("post-abort");
    checkOutput("post-abort done pulses", 32'(doneCount), 32'd1);

    // Abort and start together in IDLE: abort wins
    base_addr = 8'h11;
    num_rows  = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("abort+start no latch", 32'(tx_valid), 32'd0);

    // Second start while busy is ignored
    resetMon();
    applyStimulus(8'h50, 8'd2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    applyStimulus(8'h60, 8'd5);
    waitIdle("restart", 400, 1'b0);
    buildExpected(8'h50, 8'd2);
    checkFrame("restart");
    checkOutput("restart reads", 32'(rdQ.size()), 32'd2);
    checkOutput("restart addr0", 32'(rdQ[0]), 32'h50);
    checkOutput("restart addr1", 32'(rdQ[1]), 32'h51);
    checkOutput("restart done pulses", 32'(doneCount), 32'd1);

    // Reset asserted while the checksum byte is stalled
    resetMon();
    applyStimulus(8'h70, 8'd1);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rxQ.size() == 34) begin
        reached = 1'b1;
        break;
      end
    end
    tx_ready = 1'b0;
    checkOutput("csum reached", 32'(reached), 32'd1);
    buildExpected(8'h70, 8'd1);
    checkOutput("csum valid", 32'(tx_valid), 32'd1);
    checkOutput("csum byte", 32'(tx_data), 32'(expQ[34]));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midreset tx_data", 32'(tx_data), 32'd0);
    checkOutput("midreset ub_rd_en", 32'(ub_rd_en), 32'd0);
    checkOutput("midreset ub_rd_addr", 32'(ub_rd_addr), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("midreset no done", 32'(doneCount), 32'd0);
    checkOutput("midreset idle", 32'(busy), 32'd0);

    checkOutput("busy/done overlap", 32'(overlapViol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
